// File: rtl/vsc8541_pkg.sv
// Shared definitions for the VSC8541 register poller.
// Contents: poller FSM state encoding, transaction source encoding, MDIO
// register-address width and the standard PHY register addresses.
package vsc8541_pkg;

    localparam int MDIO_REG_W = 5;

    // Standard IEEE / VSC8541 register addresses
    localparam logic [MDIO_REG_W-1:0] BMCR     = 5'd0;
    localparam logic [MDIO_REG_W-1:0] BMSR     = 5'd1;
    localparam logic [MDIO_REG_W-1:0] PHYID1   = 5'd2;
    localparam logic [MDIO_REG_W-1:0] ANLPAR   = 5'd5;
    localparam logic [MDIO_REG_W-1:0] STAT1000 = 5'd10;
    localparam logic [MDIO_REG_W-1:0] AUXSTAT  = 5'd28;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_DV = 2'd2,
        DONE    = 2'd3
    } poller_state_t;

    typedef enum logic {
        POLL = 1'b0,
        HOST = 1'b1
    } src_t;

endpackage

// File: rtl/vsc8541_reg_poller_counter.sv
// Free-running down-counter used as the poll interval timer.
// Ports:
//   clk      - clock
//   reset    - synchronous active-high reset, loads MAX_VALUE
//   rollover - high for the one cycle the count sits at zero; the count
//              reloads MAX_VALUE on the following edge
module vsc8541_reg_poller_counter #(
    parameter int MAX_VALUE = 999999,
    parameter int WIDTH     = 20
) (
    input  logic clk,
    input  logic reset,
    output logic rollover
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= WIDTH'(MAX_VALUE);
        end else if (count == '0) begin
            count <= WIDTH'(MAX_VALUE);
        end else begin
            count <= count - 1'b1;
        end
    end

    assign rollover = (count == '0);

endmodule

// File: rtl/vsc8541_reg_poller.sv
// Arbitrating front-end for the VSC8541 MDIO register-read engine.
// Sweeps REG_LIST every POLL_INTERVAL cycles into a shadow array and serves
// one-shot host reads; host requests win arbitration in IDLE only.
// Ports:
//   clk, i_reset          - clock, synchronous active-high reset
//   o_rd_register/o_rd_en - read request to the engine (held until dv/timeout)
//   i_rd_data/i_rd_dv     - engine response, dv is a 1-cycle pulse
//   i_host_req/i_host_reg - host read request (level) and register address
//   o_host_ack/data/err   - 1-cycle completion pulse, data, timeout flag
//   o_shadow/_valid       - polled register values and per-entry valid bits
//   o_sweep_done          - 1-cycle pulse after the last entry of a sweep
//   o_timeout_cnt         - saturating count of engine timeouts
//
// Handshakes: o_rd_en rises one cycle after ISSUE and stays high with a stable
// o_rd_register until the cycle i_rd_dv is seen (or the timeout fires); it is
// low from the next cycle. i_host_req is a level held until o_host_ack; a
// request still high in the cycle after the ack is taken as a new request.
module vsc8541_reg_poller
    import vsc8541_pkg::*;
#(
    parameter int          NUM_REGS      = 4,
    parameter logic [39:0] REG_LIST      = {20'd0, 5'd17, 5'd10, 5'd5, 5'd1},
    parameter int          DATA_WIDTH    = 15,
    parameter int          POLL_INTERVAL = 1000000,
    parameter int          TIMEOUT       = 4096
) (
    input  logic                           clk,
    input  logic                           i_reset,
    output logic [MDIO_REG_W-1:0]          o_rd_register,
    output logic                           o_rd_en,
    input  logic [DATA_WIDTH-1:0]          i_rd_data,
    input  logic                           i_rd_dv,
    input  logic                           i_host_req,
    input  logic [MDIO_REG_W-1:0]          i_host_reg,
    output logic                           o_host_ack,
    output logic [DATA_WIDTH-1:0]          o_host_data,
    output logic                           o_host_err,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_shadow,
    output logic [NUM_REGS-1:0]            o_shadow_valid,
    output logic                           o_sweep_done,
    output logic [7:0]                     o_timeout_cnt
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;
    localparam int IV_W  = $clog2(POLL_INTERVAL);

    poller_state_t         state;
    src_t                  src;
    logic [MDIO_REG_W-1:0] addr;
    logic                  err;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [IDX_W-1:0]      idx;
    logic [TO_W-1:0]       to_cnt;
    logic                  poll_pending;
    logic                  interval_expired;
    logic [MDIO_REG_W-1:0] list_addr;
    logic                  last_entry;
    logic                  sweep_end;

    vsc8541_reg_poller_counter #(
        .MAX_VALUE (POLL_INTERVAL - 1),
        .WIDTH     (IV_W)
    ) u_interval (
        .clk      (clk),
        .reset    (i_reset),
        .rollover (interval_expired)
    );

    assign list_addr  = REG_LIST[idx*MDIO_REG_W +: MDIO_REG_W];
    assign last_entry = (idx == IDX_W'(NUM_REGS - 1));
    assign sweep_end  = (state == DONE) && (src == POLL) && last_entry;

    // An expiry while a sweep is still running is dropped, not queued; the
    // clear at the end of a sweep wins over a coincident expiry for the same
    // reason (pending is still set in that cycle).
    always_ff @(posedge clk) begin
        if (i_reset) begin
            poll_pending <= 1'b1;
        end else if (sweep_end) begin
            poll_pending <= 1'b0;
        end else if (interval_expired) begin
            poll_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state          <= IDLE;
            src            <= POLL;
            addr           <= '0;
            err            <= 1'b0;
            rd_data_q      <= '0;
            idx            <= '0;
            to_cnt         <= '0;
            o_rd_en        <= 1'b0;
            o_rd_register  <= '0;
            o_host_ack     <= 1'b0;
            o_host_data    <= '0;
            o_host_err     <= 1'b0;
            o_shadow       <= '0;
            o_shadow_valid <= '0;
            o_sweep_done   <= 1'b0;
            o_timeout_cnt  <= '0;
        end else begin
            o_host_ack   <= 1'b0;
            o_sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_host_req) begin
                        src   <= HOST;
                        addr  <= i_host_reg;
                        state <= ISSUE;
                    end else if (poll_pending) begin
                        src   <= POLL;
                        addr  <= list_addr;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_rd_en       <= 1'b1;
                    o_rd_register <= addr;
                    to_cnt        <= '0;
                    err           <= 1'b0;
                    state         <= WAIT_DV;
                end
                WAIT_DV: begin
                    // Host completion is registered here so the ack pulse
                    // lines up with the DONE cycle.
                    if (i_rd_dv) begin
                        rd_data_q <= i_rd_data;
                        o_rd_en   <= 1'b0;
                        state     <= DONE;
                        if (src == HOST) begin
                            o_host_ack  <= 1'b1;
                            o_host_data <= i_rd_data;
                            o_host_err  <= 1'b0;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        o_rd_en <= 1'b0;
                        err     <= 1'b1;
                        state   <= DONE;
                        if (o_timeout_cnt != 8'hFF) begin
                            o_timeout_cnt <= o_timeout_cnt + 8'd1;
                        end
                        if (src == HOST) begin
                            o_host_ack  <= 1'b1;
                            o_host_data <= '0;
                            o_host_err  <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (src == POLL) begin
                        if (!err) begin
                            o_shadow[idx*DATA_WIDTH +: DATA_WIDTH] <= rd_data_q;
                            o_shadow_valid[idx]                    <= 1'b1;
                        end
                        if (last_entry) begin
                            idx          <= '0;
                            o_sweep_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vsc8541_reg_poller.sv
module tb_vsc8541_reg_poller;

    localparam int          NR = 4;
    localparam int          DW = 15;
    localparam int          PI = 300;
    localparam int          TO = 128;
    localparam logic [39:0] RL = {20'd0, 5'd17, 5'd10, 5'd5, 5'd1};

    logic             clk = 1'b0;
    logic             i_reset;
    logic [4:0]       o_rd_register;
    logic             o_rd_en;
    logic [DW-1:0]    i_rd_data;
    logic             i_rd_dv;
    logic             i_host_req;
    logic [4:0]       i_host_reg;
    logic             o_host_ack;
    logic [DW-1:0]    o_host_data;
    logic             o_host_err;
    logic [NR*DW-1:0] o_shadow;
    logic [NR-1:0]    o_shadow_valid;
    logic             o_sweep_done;
    logic [7:0]       o_timeout_cnt;

    vsc8541_reg_poller #(
        .NUM_REGS(NR), .REG_LIST(RL), .DATA_WIDTH(DW),
        .POLL_INTERVAL(PI), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .i_reset(i_reset),
        .o_rd_register(o_rd_register), .o_rd_en(o_rd_en),
        .i_rd_data(i_rd_data), .i_rd_dv(i_rd_dv),
        .i_host_req(i_host_req), .i_host_reg(i_host_reg),
        .o_host_ack(o_host_ack), .o_host_data(o_host_data), .o_host_err(o_host_err),
        .o_shadow(o_shadow), .o_shadow_valid(o_shadow_valid),
        .o_sweep_done(o_sweep_done), .o_timeout_cnt(o_timeout_cnt)
    );

    always #5 clk = ~clk;

    // Reference: polled list in index order
    int reg_addr [NR] = '{1, 5, 10, 17};

    int tests = 0;
    int fails = 0;

    // Written by the directed sequence, read by the engine model
    int dead_addr = 10;
    int lat_lo    = 10;
    int lat_hi    = 40;
    int spur_req  = 0;

    // Written by the engine/monitor, read by the directed sequence
    int            cyc       = 0;
    int            sweep_cnt = 0;
    int            fin17     = 0;
    int            unstable  = 0;
    logic [4:0]    issued_q [$];
    int            len_q    [$];
    int            start_q  [$];
    logic [DW:0]   ack_q    [$];
    logic [DW-1:0] last_data [32];
    bit            got       [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shadow entry k must hold the latest successful engine response for its
    // register since the last reset, or 0 with valid clear if there is none.
    task automatic check_shadow(input string tag);
        for (int k = 0; k < NR; k++) begin
            logic [DW-1:0] e;
            e = got[reg_addr[k]] ? last_data[reg_addr[k]] : '0;
            chk($sformatf("%s_sh%0d", tag, k), 64'(o_shadow[k*DW +: DW]), 64'(e));
            chk($sformatf("%s_v%0d", tag, k), 64'(o_shadow_valid[k]), 64'(got[reg_addr[k]]));
        end
    endtask

    task automatic wait_sweeps(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (sweep_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(sweep_cnt >= target), 64'(1));
    endtask

    task automatic check_seq(input string tag, input int base, input int exp_list [$]);
        chk({tag, "_n"}, 64'(issued_q.size() - base), 64'(exp_list.size()));
        for (int k = 0; k < exp_list.size() && base + k < issued_q.size(); k++)
            chk($sformatf("%s_a%0d", tag, k), 64'(issued_q[base+k]), 64'(exp_list[k]));
    endtask

    // Engine model and passive monitor, both sampled on the falling edge
    initial begin
        int         cnt, lat, cur_len;
        logic [4:0] cur;
        logic       prev_en;
        int         spur_done;
        logic [DW-1:0] d;
        cnt = 0; lat = 0; cur_len = 0; cur = '0; prev_en = 1'b0; spur_done = 0;
        i_rd_dv = 1'b0;
        i_rd_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            i_rd_dv = 1'b0;
            if (i_reset)
                for (int k = 0; k < 32; k++) got[k] = 1'b0;
            if (o_rd_en && !prev_en) begin
                issued_q.push_back(o_rd_register);
                cur = o_rd_register;
                cnt = 0;
                cur_len = 1;
                lat = $urandom_range(lat_hi, lat_lo);
                if (o_rd_register == 5'd1) start_q.push_back(cyc);
            end else if (o_rd_en) begin
                cnt++;
                cur_len++;
                if (o_rd_register != cur) unstable++;
            end
            if (!o_rd_en && prev_en) begin
                len_q.push_back(cur_len);
                if (cur == 5'd17) fin17++;
            end
            if (o_sweep_done) sweep_cnt++;
            if (o_host_ack) ack_q.push_back({o_host_err, o_host_data});
            if (o_rd_en && cnt == lat && int'(cur) != dead_addr) begin
                d = DW'($urandom);
                i_rd_dv = 1'b1;
                i_rd_data = d;
                last_data[cur] = d;
                got[cur] = 1'b1;
            end else if (!o_rd_en && spur_done != spur_req) begin
                i_rd_dv = 1'b1;
                i_rd_data = DW'($urandom);
                spur_done++;
            end
            prev_en = o_rd_en;
        end
    end

    initial begin
        int bi, bl, ba, sw, n, bs, b17;
        logic [NR*DW-1:0] sh_save;
        logic [NR-1:0]    v_save;
        i_reset = 1'b1;
        i_host_req = 1'b0;
        i_host_reg = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rd_en", 64'(o_rd_en), 64'(0));
        chk("rst_rd_reg", 64'(o_rd_register), 64'(0));
        chk("rst_ack", 64'(o_host_ack), 64'(0));
        chk("rst_hdata", 64'(o_host_data), 64'(0));
        chk("rst_herr", 64'(o_host_err), 64'(0));
        chk("rst_shadow", 64'(o_shadow), 64'(0));
        chk("rst_valid", 64'(o_shadow_valid), 64'(0));
        chk("rst_sdone", 64'(o_sweep_done), 64'(0));
        chk("rst_tocnt", 64'(o_timeout_cnt), 64'(0));
        i_reset = 1'b0;

        // Sweep 1: register 10 never answers
        bi = issued_q.size(); bl = len_q.size(); sw = sweep_cnt;
        wait_sweeps("a_sweep", sw + 1, 400);
        check_seq("a_seq", bi, '{1, 5, 10, 17});
        chk("a_to_len", 64'(len_q.size() > bl + 2 ? len_q[bl+2] : -1), 64'(TO));
        chk("a_tocnt", 64'(o_timeout_cnt), 64'(1));
        chk("a_valid", 64'(o_shadow_valid), 64'(4'b1011));
        check_shadow("a");
        repeat (3) @(negedge clk);
        chk("a_one_done", 64'(sweep_cnt), 64'(sw + 1));

        // Sweep 2: host read of reg 2 raised during the reg 5 poll read
        dead_addr = -1;
        bi = issued_q.size(); ba = ack_q.size(); sw = sweep_cnt;
        n = 0;
        while (!(o_rd_en && o_rd_register == 5'd5) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b_reg5_seen", 64'(o_rd_en && o_rd_register == 5'd5), 64'(1));
        i_host_reg = 5'd2;
        i_host_req = 1'b1;
        n = 0;
        while (!o_host_ack && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("b_ack_seen", 64'(o_host_ack), 64'(1));
        chk("b_ack_data", 64'(o_host_data), 64'(last_data[2]));
        chk("b_ack_err", 64'(o_host_err), 64'(0));
        i_host_req = 1'b0;
        wait_sweeps("b_sweep", sw + 1, 400);
        repeat (3) @(negedge clk);
        check_seq("b_seq", bi, '{1, 5, 2, 10, 17});
        chk("b_acks", 64'(ack_q.size() - ba), 64'(1));
        chk("b_hold_data", 64'(o_host_data), 64'(last_data[2]));
        chk("b_valid", 64'(o_shadow_valid), 64'(4'hF));
        chk("b_tocnt", 64'(o_timeout_cnt), 64'(1));
        check_shadow("b");

        // Spurious dv while idle
        sh_save = o_shadow; v_save = o_shadow_valid; ba = ack_q.size();
        spur_req = spur_req + 1;
        repeat (6) @(negedge clk);
        chk("c_shadow", 64'(o_shadow), 64'(sh_save));
        chk("c_valid", 64'(o_shadow_valid), 64'(v_save));
        chk("c_acks", 64'(ack_q.size() - ba), 64'(0));
        chk("c_rd_en", 64'(o_rd_en), 64'(0));

        // Reset while a poll read is waiting for dv
        n = 0;
        while (!o_rd_en && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("d_rd_en_up", 64'(o_rd_en), 64'(1));
        repeat (5) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        chk("d_rd_en", 64'(o_rd_en), 64'(0));
        chk("d_rd_reg", 64'(o_rd_register), 64'(0));
        chk("d_shadow", 64'(o_shadow), 64'(0));
        chk("d_valid", 64'(o_shadow_valid), 64'(0));
        chk("d_tocnt", 64'(o_timeout_cnt), 64'(0));
        chk("d_hdata", 64'(o_host_data), 64'(0));
        chk("d_sdone", 64'(o_sweep_done), 64'(0));
        @(negedge clk);
        i_reset = 1'b0;
        n = 0;
        while (!o_rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("d_restart_en", 64'(o_rd_en), 64'(1));
        chk("d_restart_reg", 64'(o_rd_register), 64'(1));

        // Sweep longer than the interval: expiries during a sweep are dropped
        lat_lo = 100;
        lat_hi = 120;
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        bi = issued_q.size(); bs = start_q.size(); sw = sweep_cnt; b17 = fin17;
        i_reset = 1'b0;
        repeat (1900) @(negedge clk);
        chk("e_starts", 64'(start_q.size() - bs), 64'(4));
        for (int k = 1; k < 4 && bs + k < start_q.size(); k++)
            chk($sformatf("e_gap%0d", k), 64'(start_q[bs+k] - start_q[bs+k-1]), 64'(2 * PI));
        chk("e_sweeps", 64'(sweep_cnt - sw), 64'(3));
        chk("e_fin17", 64'(fin17 - b17), 64'(3));
        for (int k = bi; k < issued_q.size(); k++)
            chk($sformatf("e_a%0d", k - bi), 64'(issued_q[k]), 64'(reg_addr[(k - bi) % NR]));
        chk("e_tocnt", 64'(o_timeout_cnt), 64'(0));
        chk("stable_reg", 64'(unstable), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vsc8541_reg_poller.md
Name: vsc8541_reg_poller

Overview:
- Controller in front of the VSC8541 MDIO register-read engine; the engine is not modified.
- Sweeps a fixed list of PHY registers every POLL_INTERVAL cycles and keeps a shadow copy of each result.
- Also serves one-shot host reads. Host requests take priority over polling, and the two are arbitrated one MDIO transaction at a time.
- Sits between the link/status logic and the single shared engine instance.

Parameters:
- NUM_REGS, 4, number of registers polled per sweep (1..8)
- REG_LIST, {5'd1,5'd5,5'd10,5'd17} as 40-bit packed (entry k at bits [5k+4:5k]), register addresses polled in index order
- DATA_WIDTH, 15, width of engine read data
- POLL_INTERVAL, 1000000, cycles from start of one sweep to start of the next (>= 2)
- TIMEOUT, 4096, cycles allowed between issuing a read and seeing i_rd_dv

Ports:
- clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- o_rd_register  out  5  register address to engine
- o_rd_en  out  1  read request to engine
- i_rd_data  in  DATA_WIDTH  engine read data
- i_rd_dv  in  1  engine data-valid pulse (1 cycle)
- i_host_req  in  1  host read request, level, held until o_host_ack
- i_host_reg  in  5  host register address, stable while i_host_req
- o_host_ack  out  1  1-cycle pulse when the host result is ready
- o_host_data  out  DATA_WIDTH  host result, valid with o_host_ack, held until next ack
- o_host_err  out  1  qualifies o_host_ack: 1 = timed out, o_host_data = 0
- o_shadow  out  NUM_REGS*DATA_WIDTH  shadow values, entry k at [k*DATA_WIDTH +: DATA_WIDTH]
- o_shadow_valid  out  NUM_REGS  bit k set once entry k has been read successfully
- o_sweep_done  out  1  1-cycle pulse at the end of each sweep
- o_timeout_cnt  out  8  saturating count of timeouts

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on i_reset.
- Reset values: all outputs 0, and the shadow array is 0. The interval counter is loaded with POLL_INTERVAL-1. poll_pending = 1, so the first sweep starts right after reset.
- Interval counter: counts down every cycle, independent of the FSM. At 0 it reloads POLL_INTERVAL-1 and sets poll_pending.
  - If poll_pending is already set (a sweep is still running), the expiry is dropped and no queueing occurs.
- FSM states: IDLE, ISSUE, WAIT_DV, DONE.
- IDLE:
  - If i_host_req: latch src=HOST and addr=i_host_reg, go to ISSUE.
  - Else if poll_pending: latch src=POLL and addr=REG_LIST[idx], go to ISSUE.
  - Else stay in IDLE.
- ISSUE (1 cycle):
  - Set o_rd_en=1 and o_rd_register=addr.
  - Clear the timeout counter.
  - Go to WAIT_DV.
- WAIT_DV:
  - Hold o_rd_en and o_rd_register stable.
  - The timeout counter increments each cycle.
  - In the cycle i_rd_dv=1: capture i_rd_data, clear o_rd_en (registered, low from the next cycle), go to DONE.
  - If the counter reaches TIMEOUT-1 without dv: clear o_rd_en, increment o_timeout_cnt (saturating at 255), go to DONE with err=1.
- DONE (1 cycle):
  - src=HOST: pulse o_host_ack, drive o_host_data (0 on err), drive o_host_err.
  - src=POLL, no err: write shadow[idx] and set o_shadow_valid[idx].
  - src=POLL, err: keep shadow[idx] and o_shadow_valid[idx] unchanged.
  - For POLL in either case: if idx==NUM_REGS-1, set idx=0, clear poll_pending and pulse o_sweep_done; else idx++.
  - Always return to IDLE.
- Arbitration:
  - Evaluated only in IDLE, so a host request never preempts an in-flight poll read. It is served next, between two sweep entries.
  - The host still waits up to one full transaction.
- Host handshake:
  - o_host_ack is asserted only for a request that was sampled.
  - i_host_req sampled high again in the cycle after ack starts a new transaction, so the host must drop req on ack to avoid a repeat.
- i_rd_dv outside WAIT_DV is ignored.
- Reset mid-operation: FSM goes to IDLE and o_rd_en drops at once. The engine is reset by the same i_reset, so no orphan transaction remains.
- Widths:
  - idx: $clog2(NUM_REGS) bits, minimum 1.
  - Timeout counter: $clog2(TIMEOUT)+1 bits.
  - Interval counter: $clog2(POLL_INTERVAL) bits.

Decomposition:
- Package vsc8541_pkg:
  - poller_state_t enum (IDLE, ISSUE, WAIT_DV, DONE)
  - src_t enum (POLL, HOST)
  - MDIO_REG_W=5
  - Standard register address constants (BMCR=0, BMSR=1, PHYID1=2, ANLPAR=5, STAT1000=10, AUXSTAT=28)
- Sub-module: the interval timer reuses the existing counter module with MAX_VALUE=POLL_INTERVAL-1. Its rollover sets poll_pending.
- Everything else lives in one file.

Test Plan:
- Engine model answers each read 40 cycles after o_rd_en with data = {10'h0, addr}; POLL_INTERVAL=500 -> after reset, o_rd_register = 1,5,10,17 in order; o_shadow entries = 1,5,10,17; o_shadow_valid=4'hF; o_sweep_done pulses once per sweep.
- i_host_req with i_host_reg=2 asserted while the poll read of reg 5 is in WAIT_DV -> the reg 5 read completes, then one host read of 2 follows; o_host_ack with o_host_data=2; the sweep then resumes at reg 10.
- Engine never returns dv for reg 10 (TIMEOUT=64) -> o_rd_en drops 64 cycles after issue; o_timeout_cnt=1; o_shadow_valid[2] stays 0; reg 17 is still read.
- POLL_INTERVAL=100 with a 40-cycle engine (sweep exceeds the interval) -> no overlapping or double sweeps; o_sweep_done at most once per completed sweep; the dropped expiry is not queued.
- i_reset pulsed during WAIT_DV -> the next cycle has o_rd_en=0, all outputs 0, o_shadow_valid=0; the sweep restarts at reg 1.
- i_rd_dv spurious pulse while IDLE -> no shadow write, no ack.
